// File: rtl/common_pkg.sv
// Shared types for the systolic array block: array size, element type, scheduler states.
package common_pkg;

   localparam int SYS_ARRAY_SIZE = 4;
   localparam int DATA_W         = 16;

   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/systolic_array_sched.sv
// Job scheduler for a systolic array: takes k_len operand beats from upstream,
// presents them to the array one cycle later (zeros in bubbles), flags the last
// beat, waits DRAIN_CYC cycles for the result and pulses res_valid_o.
module systolic_array_sched
   import common_pkg::*;
#(
   parameter int K_W       = 16,
   parameter int DRAIN_CYC = 2 * SYS_ARRAY_SIZE
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic [K_W-1:0]             k_len_i,
   input  logic                       abort_i,
   input  logic                       op_valid_i,
   output logic                       op_ready_o,
   input  data_t [SYS_ARRAY_SIZE-1:0] op_a_i,
   input  data_t [SYS_ARRAY_SIZE-1:0] op_b_i,
   output data_t [SYS_ARRAY_SIZE-1:0] arr_a_o,
   output data_t [SYS_ARRAY_SIZE-1:0] arr_b_o,
   output logic                       arr_last_o,
   output logic                       busy_o,
   output logic                       res_valid_o,
   output logic                       err_o
);

   // Wide enough to hold DRAIN_CYC-1 even for DRAIN_CYC == 1.
   localparam int                DC_W       = $clog2(DRAIN_CYC + 1);
   localparam logic [DC_W-1:0]   DRAIN_LOAD = DC_W'(DRAIN_CYC - 1);

   sched_state_t    state, state_nxt;
   logic [K_W-1:0]  k_len_q;
   logic [K_W-1:0]  beat_cnt;   // beats accepted so far; never exceeds k_len
   logic [DC_W-1:0] drain_cnt;
   logic            kill;
   logic            accept;
   logic            last_beat;
   logic            start_ok;

   // Abort only means something while a job is running.
   assign kill       = abort_i && (state != IDLE);
   assign op_ready_o = (state == FEED);
   assign accept     = op_valid_i && op_ready_o;
   // Compare against k_len-1 so a full-scale k_len never needs a wider counter.
   assign last_beat  = (beat_cnt == (k_len_q - K_W'(1)));
   assign start_ok   = (state == IDLE) && start_i && (k_len_i != '0);
   assign busy_o      = (state != IDLE);
   assign res_valid_o = (state == DONE) && !abort_i;

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      state_nxt = state;
      if (kill) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (start_ok)                state_nxt = FEED;
            FEED:    if (accept && last_beat)     state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == '0)         state_nxt = DONE;
            DONE:                                 state_nxt = IDLE;
            default:                              state_nxt = IDLE;
         endcase
      end
   end

   // Job length, beat and drain counters, and the illegal-start flag.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         k_len_q   <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
         err_o     <= 1'b0;
      end else begin
         err_o <= (state == IDLE) && start_i && (k_len_i == '0);
         if (start_ok) begin
            k_len_q  <= k_len_i;
            beat_cnt <= '0;
         end else if (accept && !kill) begin
            beat_cnt <= beat_cnt + K_W'(1);
         end
         if (accept && !kill && last_beat)
            drain_cnt <= DRAIN_LOAD;
         else if ((state == DRAIN) && (drain_cnt != '0))
            drain_cnt <= drain_cnt - DC_W'(1);
      end
   end

   // Operand pipeline to the array: accepted beat or zeros, one cycle later.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         arr_a_o    <= '0;
         arr_b_o    <= '0;
         arr_last_o <= 1'b0;
      end else if (accept && !kill) begin
         arr_a_o    <= op_a_i;
         arr_b_o    <= op_b_i;
         arr_last_o <= last_beat;
      end else begin
         arr_a_o    <= '0;
         arr_b_o    <= '0;
         arr_last_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_systolic_array_sched.sv
// Directed + randomized bench for systolic_array_sched with a job-level reference model.
module tb_systolic_array_sched;
   import common_pkg::*;

   localparam int N  = SYS_ARRAY_SIZE;
   localparam int KW = 4;
   localparam int DC = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [KW-1:0] k_len = '0;
   logic          abort = 1'b0;
   logic          valid = 1'b0;
   data_t [N-1:0] op_a = '0;
   data_t [N-1:0] op_b = '0;
   data_t [N-1:0] arr_a, arr_b;
   logic          ready, last, busy, res_valid, err;

   int n_chk  = 0;
   int n_pass = 0;
   longint cs_nogap, cs_gap, cs_dummy;

   always #5 clk = ~clk;

   systolic_array_sched #(.K_W(KW), .DRAIN_CYC(DC)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .k_len_i(k_len), .abort_i(abort),
      .op_valid_i(valid), .op_ready_o(ready), .op_a_i(op_a), .op_b_i(op_b),
      .arr_a_o(arr_a), .arr_b_o(arr_b), .arr_last_o(last), .busy_o(busy),
      .res_valid_o(res_valid), .err_o(err)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, ".ready"}, 64'(ready), 0);
      chk({tag, ".busy"},  64'(busy), 0);
      chk({tag, ".res"},   64'(res_valid), 0);
      chk({tag, ".err"},   64'(err), 0);
      chk({tag, ".last"},  64'(last), 0);
      chk({tag, ".arr_a"}, 64'(arr_a), 0);
      chk({tag, ".arr_b"}, 64'(arr_b), 0);
   endtask

   function automatic data_t opval(input int seed, input int beat, input int i);
      return data_t'((seed * 131 + beat * 17 + i * 7 + 3) % 251);
   endfunction

   // Quiet cycles: nothing may happen while idle.
   task automatic idle_check(input string tag, input int n);
      int bad = 0;
      for (int c = 0; c < n; c++) begin
         #1; start = 1'b0; valid = 1'b1; abort = 1'b0;
         @(negedge clk);
         if (res_valid !== 1'b0 || busy !== 1'b0 || ready !== 1'b0 || arr_a !== '0) bad++;
         @(posedge clk);
      end
      chk({tag, ".quiet"}, 64'(bad), 0);
   endtask

   // Runs one job from its start cycle (c=0). mode: 0 valid always, 1 toggling, 2 random.
   // abort_beat>0 aborts while that beat is offered; rst_c>=0 pulls reset at that cycle.
   task automatic do_job(input string tag, input int k, input int mode, input int abort_beat,
                         input int rst_c, input int seed, input bit noisy, output longint csum);
      longint ref_c [N][N];
      longint obs_c [N][N];
      data_t [N-1:0] pa, pb;
      int  n_acc = 0, last_c = -1, done_c, end_c, bad_c = 0;
      int  bad_rdy = 0, bad_busy = 0, bad_arr = 0, bad_last = 0, bad_res = 0, bad_err = 0, n_res = 0;
      bit  feeding = 0, prev_acc = 0, prev_last = 0, finished = 0, hit_rst = 0, c_checked = 0;
      bit  v, acc_now, exp_busy;
      csum = 0;
      pa = '0; pb = '0;
      end_c = (k == 0) ? 2 : -1;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin ref_c[i][j] = 0; obs_c[i][j] = 0; end
      for (int c = 0; c < 300 && !finished; c++) begin
         done_c = (last_c >= 0) ? last_c + 1 + DC : -1;
         exp_busy = feeding || (last_c >= 0 && c <= done_c);
         #1;
         v = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 2) == 1) : 1'($urandom_range(0, 1));
         start = (c == 0) ? 1'b1 : (noisy && exp_busy) ? 1'($urandom_range(0, 1)) : 1'b0;
         k_len = (c == 0) ? KW'(k) : KW'($urandom);
         valid = v;
         abort = feeding && (abort_beat > 0) && (n_acc == abort_beat - 1) && v;
         for (int i = 0; i < N; i++) begin
            op_a[i] = opval(seed, n_acc, i);
            op_b[i] = opval(seed + 1000, n_acc, i);
         end
         @(negedge clk);
         if (ready !== feeding) bad_rdy++;
         if (busy !== exp_busy) bad_busy++;
         if (arr_a !== (prev_acc ? pa : '0) || arr_b !== (prev_acc ? pb : '0)) bad_arr++;
         if (last !== prev_last) bad_last++;
         if (err !== (k == 0 && c == 1)) bad_err++;
         if (res_valid === 1'b1) n_res++;
         if (res_valid !== (c == done_c)) bad_res++;
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               obs_c[i][j] += longint'(arr_a[i]) * longint'(arr_b[j]);
         if (c == done_c) begin
            c_checked = 1;
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++) begin
                  if (obs_c[i][j] != ref_c[i][j]) bad_c++;
                  csum += obs_c[i][j] * (i * N + j + 1);
               end
         end
         if (c == rst_c) begin
            #1 rst = 1'b0;
            #1 chk_zero({tag, ".rst"});
            hit_rst = 1; finished = 1;
         end else begin
            acc_now = feeding && v && !abort;
            prev_acc = acc_now; prev_last = 0;
            if (acc_now) begin
               pa = op_a; pb = op_b; n_acc++;
               for (int i = 0; i < N; i++)
                  for (int j = 0; j < N; j++)
                     ref_c[i][j] += longint'(op_a[i]) * longint'(op_b[j]);
               if (n_acc == k) begin
                  last_c = c; prev_last = 1; feeding = 0; end_c = c + 1 + DC;
               end
            end
            if (abort) begin feeding = 0; end_c = c + 1; end
            if (c == 0) feeding = (k != 0);
            @(posedge clk);
            if (c == end_c) finished = 1;
         end
      end
      abort = 1'b0; start = 1'b0;
      chk({tag, ".finished"}, 64'(finished), 1);
      chk({tag, ".ready"}, 64'(bad_rdy), 0);
      chk({tag, ".busy"}, 64'(bad_busy), 0);
      chk({tag, ".arr"}, 64'(bad_arr), 0);
      chk({tag, ".last"}, 64'(bad_last), 0);
      chk({tag, ".err"}, 64'(bad_err), 0);
      chk({tag, ".res_timing"}, 64'(bad_res), 0);
      chk({tag, ".res_count"}, 64'(n_res), (last_c >= 0 && !hit_rst) ? 1 : 0);
      if (c_checked) chk({tag, ".c"}, 64'(bad_c), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);

      do_job("k3", 3, 0, 0, -1, 11, 0, cs_dummy);
      do_job("k4_nogap", 4, 0, 0, -1, 22, 0, cs_nogap);
      do_job("k4_gap", 4, 1, 0, -1, 22, 0, cs_gap);
      chk("gap_same_c", 64'(cs_gap), 64'(cs_nogap));
      do_job("k0", 0, 0, 0, -1, 5, 0, cs_dummy);
      idle_check("after_k0", 2);
      do_job("abort5", 5, 0, 2, -1, 33, 0, cs_dummy);
      do_job("after_abort", 2, 0, 0, -1, 44, 0, cs_dummy);
      // Back-to-back: the second start lands in the cycle right after DONE.
      do_job("b2b_k2", 2, 0, 0, -1, 55, 0, cs_dummy);
      do_job("b2b_k1", 1, 0, 0, -1, 66, 0, cs_dummy);
      // Reset during DRAIN (k=2, valid every cycle: drain spans cycles 3..10).
      do_job("rst_drain", 2, 0, 0, 5, 77, 0, cs_dummy);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      idle_check("after_rst", 15);
      do_job("kmax", 15, 2, 0, -1, int'($urandom_range(0, 100000)), 1, cs_dummy);
      for (int r = 0; r < 6; r++)
         do_job($sformatf("rnd%0d", r), int'($urandom_range(1, 6)), 2, 0, -1,
                int'($urandom_range(0, 100000)), 1, cs_dummy);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
